// File: rtl/ibf_pkg.sv
// Shared types and helper functions for the runtime-reconfigurable
// inverse-butterfly parallel-extract engine.
//   state_e   : commit FSM states (run / drain / swap)
//   pop_cnt   : number of set bits, used to derive pipeline latency
//   stg_cfg_w : control-word width of one butterfly stage
//   mux_cfg_w : control-word width of the N:1 lane mux
//   sel_w     : width of the config target selector
package ibf_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StSwap  = 2'd2
  } state_e;

  function automatic int unsigned pop_cnt(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  function automatic int unsigned stg_cfg_w(input int unsigned dw);
    return dw / 2;
  endfunction

  function automatic int unsigned mux_cfg_w(input int unsigned dw, input int unsigned n);
    return $clog2(n) * (dw / n);
  endfunction

  function automatic int unsigned sel_w(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/ibf_rt_stage.sv
// One inverse-butterfly stage. Pair k swaps bits i and i+2**STAGE_ORDER when
// ctrl_i[k] is set. When IS_PIPED, the {valid, mode, data} triple is registered
// and advances only when en_i is high; otherwise the stage is pure combinational.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en_i                  global pipeline advance enable
//   valid_i/mode_i/data_i item entering the stage
//   ctrl_i                per-pair swap controls (already looked up by mode_i)
//   valid_o/mode_o/data_o item leaving the stage
module ibf_rt_stage #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MODE_WIDTH  = 2,
  parameter int unsigned STAGE_ORDER = 0,
  parameter bit          IS_PIPED    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic [MODE_WIDTH-1:0]   mode_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/2-1:0] ctrl_i,
  output logic                    valid_o,
  output logic [MODE_WIDTH-1:0]   mode_o,
  output logic [DATA_WIDTH-1:0]   data_o
);

  localparam int Dist = 1 << STAGE_ORDER;

  logic [DATA_WIDTH-1:0] swapped;

  // Pair k maps to the low bit of its block of 2*Dist plus the offset inside it.
  always_comb begin
    swapped = data_i;
    for (int k = 0; k < DATA_WIDTH / 2; k++) begin
      if (ctrl_i[k]) begin
        swapped[(k / Dist) * 2 * Dist + k % Dist]        = data_i[(k / Dist) * 2 * Dist + k % Dist + Dist];
        swapped[(k / Dist) * 2 * Dist + k % Dist + Dist] = data_i[(k / Dist) * 2 * Dist + k % Dist];
      end
    end
  end

  if (IS_PIPED) begin : g_reg
    logic                  valid_q;
    logic [MODE_WIDTH-1:0] mode_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        mode_q  <= '0;
        data_q  <= '0;
      end else if (en_i) begin
        valid_q <= valid_i;
        mode_q  <= mode_i;
        data_q  <= swapped;
      end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign data_o  = data_q;
  end else begin : g_comb
    assign valid_o = valid_i;
    assign mode_o  = mode_i;
    assign data_o  = swapped;
  end

endmodule

// File: rtl/ibf_pex_rt.sv
// Runtime-reconfigurable inverse-butterfly parallel-extract engine.
// A word passes STAGE_NUM butterfly stages and a registered N_NUM:1 per-bit lane
// mux; every stage and the mux look up their control word in the active config
// bank at the item's own mode tag. Config writes go to a shadow bank; a commit
// drains the pipe, then copies shadow to active in a single SWAP cycle.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   in_valid_i/in_ready_o              input handshake
//   in_mode_i/in_data_i                item mode tag and data word
//   out_valid_o/out_ready_i            output handshake
//   out_data_o                         extracted DATA_WIDTH/N_NUM bits
//   cfg_we_i/cfg_mode_i/cfg_sel_i      shadow write (sel = stage, or STAGE_NUM = mux)
//   cfg_wdata_i                        control word to write
//   cfg_commit_i                       request shadow->active copy
//   cfg_busy_o                         commit in progress (drain or swap)
module ibf_pex_rt
  import ibf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MODE_WIDTH = 2,
  parameter int unsigned STAGE_NUM  = 4,
  parameter logic [31:0] PIPED_MASK = 32'hF,
  parameter int unsigned N_NUM      = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [MODE_WIDTH-1:0]              in_mode_i,
  input  logic [DATA_WIDTH-1:0]              in_data_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [DATA_WIDTH/N_NUM-1:0]        out_data_o,
  input  logic                               cfg_we_i,
  input  logic [MODE_WIDTH-1:0]              cfg_mode_i,
  input  logic [$clog2(STAGE_NUM+1)-1:0]     cfg_sel_i,
  input  logic [DATA_WIDTH/2-1:0]            cfg_wdata_i,
  input  logic                               cfg_commit_i,
  output logic                               cfg_busy_o
);

  localparam int unsigned NModes  = 2 ** MODE_WIDTH;
  localparam int unsigned StgCfgW = stg_cfg_w(DATA_WIDTH);
  localparam int unsigned MuxCfgW = mux_cfg_w(DATA_WIDTH, N_NUM);
  localparam int unsigned SelW    = sel_w(STAGE_NUM);
  localparam int unsigned OutW    = DATA_WIDTH / N_NUM;
  localparam int unsigned LaneW   = $clog2(N_NUM);

  state_e state_q, state_d;
  logic   en;
  logic   pipe_busy;

  // Index 0 is the accepted input; index s+1 is the output of stage s.
  logic [STAGE_NUM:0]                 v_chain;
  logic [STAGE_NUM:0][MODE_WIDTH-1:0] m_chain;
  logic [STAGE_NUM:0][DATA_WIDTH-1:0] d_chain;
  logic [STAGE_NUM-1:0][StgCfgW-1:0]  stg_ctrl;

  logic [StgCfgW-1:0] stg_shadow_q [NModes][STAGE_NUM];
  logic [StgCfgW-1:0] stg_active_q [NModes][STAGE_NUM];
  logic [MuxCfgW-1:0] mux_shadow_q [NModes];
  logic [MuxCfgW-1:0] mux_active_q [NModes];

  logic [MuxCfgW-1:0] mux_ctrl;
  logic [OutW-1:0]    mux_d;
  logic               out_valid_q;
  logic [OutW-1:0]    out_data_q;

  // Downstream backpressure freezes the whole pipe, so in_ready is
  // combinational from out_ready_i.
  assign en = !out_valid_q | out_ready_i;

  assign v_chain[0] = in_valid_i & in_ready_o;
  assign m_chain[0] = in_mode_i;
  assign d_chain[0] = in_data_i;

  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    assign stg_ctrl[s] = stg_active_q[m_chain[s]][s];

    ibf_rt_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MODE_WIDTH  (MODE_WIDTH),
      .STAGE_ORDER (s),
      .IS_PIPED    (PIPED_MASK[s])
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .valid_i (v_chain[s]),
      .mode_i  (m_chain[s]),
      .data_i  (d_chain[s]),
      .ctrl_i  (stg_ctrl[s]),
      .valid_o (v_chain[s+1]),
      .mode_o  (m_chain[s+1]),
      .data_o  (d_chain[s+1])
    );
  end

  assign pipe_busy = (|v_chain[STAGE_NUM:1]) | out_valid_q;

  // Output bit b picks bit b of lane sel, lanes being OutW-bit slices.
  always_comb begin
    mux_ctrl = mux_active_q[m_chain[STAGE_NUM]];
    mux_d    = '0;
    for (int b = 0; b < int'(OutW); b++) begin
      for (int n = 0; n < int'(N_NUM); n++) begin
        if (mux_ctrl[b*LaneW +: LaneW] == LaneW'(n)) begin
          mux_d[b] = d_chain[STAGE_NUM][n*OutW + b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      out_valid_q <= v_chain[STAGE_NUM];
      if (v_chain[STAGE_NUM]) begin
        out_data_q <= mux_d;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Config banks. A write landing in the SWAP cycle reaches shadow only; active
  // copies the pre-write shadow because both use nonblocking updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int m = 0; m < int'(NModes); m++) begin
        for (int s = 0; s < int'(STAGE_NUM); s++) begin
          stg_shadow_q[m][s] <= '0;
          stg_active_q[m][s] <= '0;
        end
        mux_shadow_q[m] <= '0;
        mux_active_q[m] <= '0;
      end
    end else begin
      if (state_q == StSwap) begin
        stg_active_q <= stg_shadow_q;
        mux_active_q <= mux_shadow_q;
      end
      if (cfg_we_i) begin
        for (int s = 0; s < int'(STAGE_NUM); s++) begin
          if (cfg_sel_i == SelW'(s)) begin
            stg_shadow_q[cfg_mode_i][s] <= cfg_wdata_i;
          end
        end
        if (cfg_sel_i == SelW'(STAGE_NUM)) begin
          mux_shadow_q[cfg_mode_i] <= cfg_wdata_i[MuxCfgW-1:0];
        end
      end
    end
  end

  // Commit FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Commit FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (cfg_commit_i) state_d = StDrain;
      StDrain: if (!pipe_busy)   state_d = StSwap;
      StSwap:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Commit FSM: outputs.
  always_comb begin
    in_ready_o = en & (state_q == StRun);
    cfg_busy_o = (state_q != StRun);
  end

endmodule

// File: tb/tb_ibf_pex_rt.sv
module tb_ibf_pex_rt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  in_mode_i;
  logic [15:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  out_data_o;
  logic        cfg_we_i;
  logic [1:0]  cfg_mode_i;
  logic [2:0]  cfg_sel_i;
  logic [7:0]  cfg_wdata_i;
  logic        cfg_commit_i;
  logic        cfg_busy_o;

  int checks = 0;
  int errors = 0;

  // Reference config banks: stage controls and mux controls per mode.
  logic [7:0] m_stg_sh  [4][4];
  logic [7:0] m_stg_act [4][4];
  logic [7:0] m_mux_sh  [4];
  logic [7:0] m_mux_act [4];

  logic [3:0] sb_q[$];

  ibf_pex_rt dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_mode_i    (in_mode_i),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .cfg_we_i     (cfg_we_i),
    .cfg_mode_i   (cfg_mode_i),
    .cfg_sel_i    (cfg_sel_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_commit_i (cfg_commit_i),
    .cfg_busy_o   (cfg_busy_o)
  );

  always #5 clk = ~clk;

  // Reference: walk each output bit back to its partner rather than walking pairs.
  function automatic logic [3:0] ref_out(input logic [15:0] din, input logic [1:0] mode);
    logic [15:0] x, y;
    logic [1:0]  sel;
    logic [7:0]  mc;
    logic [3:0]  r;
    int d;
    x = din;
    for (int s = 0; s < 4; s++) begin
      d = 1 << s;
      y = x;
      for (int p = 0; p < 16; p++) begin
        if (m_stg_act[mode][s][(p / (2 * d)) * d + (p % d)]) y[p] = x[p ^ d];
      end
      x = y;
    end
    mc = m_mux_act[mode];
    for (int b = 0; b < 4; b++) begin
      sel  = mc[b*2 +: 2];
      r[b] = x[sel * 4 + b];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 4; m++) begin
      for (int s = 0; s < 4; s++) begin
        m_stg_sh[m][s]  = 8'h00;
        m_stg_act[m][s] = 8'h00;
      end
      m_mux_sh[m]  = 8'h00;
      m_mux_act[m] = 8'h00;
    end
  endtask

  task automatic model_activate();
    m_stg_act = m_stg_sh;
    m_mux_act = m_mux_sh;
  endtask

  // Scoreboard: push on input accept, pop on output handshake.
  always @(negedge clk) begin
    logic [3:0] exp;
    if (rst_n) begin
      if (in_valid_i && in_ready_o) sb_q.push_back(ref_out(in_data_i, in_mode_i));
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, expected no output", out_data_o);
        end else begin
          exp = sb_q.pop_front();
          if (out_data_o !== exp) begin
            errors++;
            $display("FAIL sb_data: got %h, expected %h", out_data_o, exp);
          end
        end
      end
    end
  end

  task automatic cfg_write(input logic [1:0] mode, input logic [2:0] sel, input logic [7:0] data);
    @(posedge clk); #1;
    cfg_we_i = 1'b1; cfg_mode_i = mode; cfg_sel_i = sel; cfg_wdata_i = data;
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    if (sel < 3'd4) m_stg_sh[mode][sel[1:0]] = data;
    else if (sel == 3'd4) m_mux_sh[mode] = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid_i = 1'b0; in_mode_i = '0; in_data_i = '0; out_ready_i = 1'b1;
    cfg_we_i = 1'b0; cfg_mode_i = '0; cfg_sel_i = '0; cfg_wdata_i = '0; cfg_commit_i = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid_o); end
    checks++;
    if (out_data_o !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0", out_data_o); end
    checks++;
    if (cfg_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", cfg_busy_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready_o); end
  endtask

  task automatic test_default_latency();
    int n;
    @(posedge clk); #1;
    in_valid_i = 1'b1; in_mode_i = 2'd0; in_data_i = 16'hA5C3;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    n = 1;
    while (!out_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL latency: got %0d cycles, expected 5", n); end
    checks++;
    if (out_data_o !== 4'h3) begin errors++; $display("FAIL default_extract: got %h, expected 3", out_data_o); end
    @(posedge clk); #1;
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid: got %b, expected 0", out_valid_o); end
  endtask

  task automatic test_commit();
    int busy_n;
    cfg_write(2'd1, 3'd0, 8'hFF);
    cfg_write(2'd1, 3'd4, 8'hFF);
    cfg_write(2'd1, 3'd7, 8'h5A);  // out-of-range target, must be ignored
    @(posedge clk); #1;
    cfg_commit_i = 1'b1;
    @(posedge clk); #1;
    cfg_commit_i = 1'b0;
    busy_n = 0;
    while (cfg_busy_o && busy_n < 20) begin
      checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL commit_in_ready: got %b, expected 0", in_ready_o); end
      busy_n++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_n < 1 || busy_n > 2) begin errors++; $display("FAIL commit_busy_len: got %0d, expected 1..2", busy_n); end
    model_activate();
    in_valid_i = 1'b1; in_mode_i = 2'd1; in_data_i = 16'hA5C3;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    busy_n = 0;
    while (!out_valid_o && busy_n < 20) begin
      @(posedge clk); #1;
      busy_n++;
    end
    checks++;
    if (out_data_o !== 4'h5) begin errors++; $display("FAIL mode1_extract: got %h, expected 5", out_data_o); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cnt, first, last;
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        in_valid_i = 1'b1; in_mode_i = 2'(c % 2); in_data_i = 16'($urandom);
      end else begin
        in_valid_i = 1'b0;
      end
      if (out_valid_o) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      if (c < 8) begin
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: cycle %0d got %b, expected 1", c, in_ready_o); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 8 || last - first != 7) begin
      errors++;
      $display("FAIL b2b_burst: got %0d outputs over span %0d, expected 8 over 7", cnt, last - first);
    end
  endtask

  task automatic test_stall();
    logic [15:0] data [10];
    logic [3:0]  held;
    int idx, c;
    for (int i = 0; i < 10; i++) data[i] = 16'($urandom);
    idx = 0; c = 0; held = '0;
    while ((idx < 10 || out_valid_o) && c < 60) begin
      in_valid_i  = (idx < 10);
      in_mode_i   = 2'(idx % 2);
      in_data_i   = data[idx % 10];
      out_ready_i = !(c >= 7 && c <= 9);
      #1;
      if (c == 7) held = out_data_o;
      if (c >= 7 && c <= 9) begin
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b, expected 0", c, in_ready_o); end
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== held) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d got valid %b data %h, expected 1 %h", c, out_valid_o, out_data_o, held);
        end
      end
      if (in_valid_i && in_ready_o) idx++;
      @(posedge clk); #1;
      c++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0 || idx != 10) begin
      errors++;
      $display("FAIL stall_loss: got %0d pending, %0d sent, expected 0 pending, 10 sent", sb_q.size(), idx);
    end
  endtask

  task automatic test_commit_inflight();
    int c, drain_n, outs;
    bit seen;
    cfg_write(2'd1, 3'd2, 8'h0F);
    cfg_write(2'd1, 3'd4, 8'h1B);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; in_mode_i = 2'd1; in_data_i = 16'h1234 + 16'(i * 16'h1111);
      cfg_commit_i = (i == 2);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0; cfg_commit_i = 1'b0;
    c = 0; drain_n = 0; outs = 0; seen = 1'b0;
    while (cfg_busy_o && c < 30) begin
      checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL drain_in_ready: got %b, expected 0", in_ready_o); end
      if (out_valid_o) begin seen = 1'b1; outs++; end
      else if (seen) drain_n++;
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (cfg_busy_o !== 1'b0) begin errors++; $display("FAIL drain_timeout: got busy %b, expected 0", cfg_busy_o); end
    checks++;
    if (outs != 3 || drain_n != 2) begin
      errors++;
      $display("FAIL drain_swap_timing: got %0d outs, %0d idle busy cycles, expected 3, 2", outs, drain_n);
    end
    model_activate();
    in_valid_i = 1'b1; in_mode_i = 2'd1; in_data_i = 16'hA5C3;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL post_commit_pending: got %0d, expected 0", sb_q.size()); end
  endtask

  task automatic test_reset_drain();
    int n;
    cfg_write(2'd1, 3'd3, 8'hAA);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1; in_mode_i = 2'd1; in_data_i = 16'h0F0F;
      cfg_commit_i = (i == 1);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0; cfg_commit_i = 1'b0;
    checks++;
    if (cfg_busy_o !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b, expected 1", cfg_busy_o); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    model_clear();
    checks++;
    if (out_valid_o !== 1'b0 || cfg_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_reset: got valid %b busy %b, expected 0 0", out_valid_o, cfg_busy_o);
    end
    in_valid_i = 1'b1; in_mode_i = 2'd1; in_data_i = 16'hA5C3;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 4'h3) begin
      errors++;
      $display("FAIL cleared_banks: got valid %b data %h, expected 1 3", out_valid_o, out_data_o);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_latency();
    test_commit();
    test_back_to_back();
    test_stall();
    test_commit_inflight();
    test_reset_drain();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL final_pending: got %0d, expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
